// File: rtl/fetch_pkg.sv
// Shared fetch-stage definitions: bubble encoding, FSM state type and the
// default reset fetch address.
package fetch_pkg;

  // addi x0, x0, 0 -- also used by IF/ID as its bubble
  localparam logic [31:0] NOP = 32'h0000_0013;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    WAIT  = 2'd1,
    VALID = 2'd2,
    DROP  = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/fetch_resp_buf.sv
// One-entry instruction buffer with load/invalidate and a valid flag.
// Presents NOP when empty. With FETCH_BYPASS_EN the incoming word can be
// presented combinationally in the same cycle it arrives.
module fetch_resp_buf
  import fetch_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic        invalidate,
  input  logic [31:0] wdata,
`ifdef FETCH_BYPASS_EN
  input  logic        byp_en,
`endif
  output logic [31:0] instr,
  output logic        valid
);

  logic [31:0] data_q, data_d;
  logic        valid_q, valid_d;

  // Next buffer contents; load takes precedence over invalidate
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    if (invalidate) valid_d = 1'b0;
    if (load) begin
      data_d  = wdata;
      valid_d = 1'b1;
    end
  end

  // Buffer registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q  <= NOP;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  // Presented word: bypassed response, buffered word, or bubble
  always_comb begin
    instr = valid_q ? data_q : NOP;
    valid = valid_q;
`ifdef FETCH_BYPASS_EN
    if (byp_en) begin
      instr = wdata;
      valid = 1'b1;
    end
`endif
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the fetch PC, drives a single-outstanding
// req/gnt/rvalid memory port and presents PC, instruction and PC+4 to IF/ID.
// Optional macro FETCH_BYPASS_EN presents a response in the cycle it arrives.
//
// state | meaning
// FETCH | request outstanding on the port, waiting for grant
// WAIT  | request granted, waiting for response
// VALID | instruction held in buffer and presented
// DROP  | redirected while a request was in flight; discard its response
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc_if,
  output logic [31:0] instr_if,
  output logic [31:0] pc_plus4_if,
  output logic        fetch_valid
);

  fetch_state_t state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  target_pc;
  logic [31:0]  pc_next_seq;
  logic         buf_load;
  logic         buf_inv;
  logic         byp_take;

  assign target_pc   = redirect_pc & ~32'd3;
  assign pc_next_seq = pc_q + 32'd4;

  // Next-state, next-PC and memory request; redirect is checked first in
  // every state. Responses seen in FETCH or VALID are ignored.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    imem_req = 1'b0;
    buf_load = 1'b0;
    buf_inv  = 1'b0;
    byp_take = 1'b0;
    case (state_q)
      FETCH: begin
        imem_req = 1'b1;
        if (redirect) begin
          pc_d    = target_pc;
          state_d = imem_gnt ? DROP : FETCH;
        end else if (imem_gnt) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (redirect) begin
          pc_d    = target_pc;
          state_d = imem_rvalid ? FETCH : DROP;
        end else if (imem_rvalid) begin
`ifdef FETCH_BYPASS_EN
          if (!stall) begin
            byp_take = 1'b1;
            pc_d     = pc_next_seq;
            state_d  = FETCH;
          end else begin
            buf_load = 1'b1;
            state_d  = VALID;
          end
`else
          buf_load = 1'b1;
          state_d  = VALID;
`endif
        end
      end
      VALID: begin
        if (redirect) begin
          pc_d    = target_pc;
          buf_inv = 1'b1;
          state_d = FETCH;
        end else if (!stall) begin
          pc_d    = pc_next_seq;
          buf_inv = 1'b1;
          state_d = FETCH;
        end
      end
      DROP: begin
        if (redirect) pc_d = target_pc;
        if (imem_rvalid) state_d = FETCH;
      end
      default: state_d = FETCH;
    endcase
  end

  // State and PC registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FETCH;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  fetch_resp_buf u_resp_buf (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (buf_load),
    .invalidate (buf_inv),
    .wdata      (imem_rdata),
`ifdef FETCH_BYPASS_EN
    .byp_en     (byp_take),
`endif
    .instr      (instr_if),
    .valid      (fetch_valid)
  );

`ifndef FETCH_BYPASS_EN
  logic unused_byp;
  assign unused_byp = byp_take;
`endif

  // Presented PC tracks the fetch PC; PC+4 wraps at 32 bits
  always_comb begin
    imem_addr   = pc_q;
    pc_if       = pc_q;
    pc_plus4_if = pc_next_seq;
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with RESET_PC = 0x1000. Memory handshakes
// are driven by hand each cycle; inputs change just after the falling edge
// and outputs are checked 1ns later.
module tb_fetch_unit;
  import fetch_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] pc_if;
  logic [31:0] instr_if;
  logic [31:0] pc_plus4_if;
  logic        fetch_valid;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(32'h0000_1000)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .pc_if       (pc_if),
    .instr_if    (instr_if),
    .pc_plus4_if (pc_plus4_if),
    .fetch_valid (fetch_valid)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic g, input logic rv, input logic [31:0] rd,
                      input logic st, input logic rdir, input logic [31:0] rpc);
    @(negedge clk);
    imem_gnt    = g;
    imem_rvalid = rv;
    imem_rdata  = rd;
    stall       = st;
    redirect    = rdir;
    redirect_pc = rpc;
    #1;
  endtask

  task automatic chk_idle(input string tag, input logic [31:0] pc);
    chk({tag, "_req"},   {31'd0, imem_req}, 32'd0);
    chk({tag, "_valid"}, {31'd0, fetch_valid}, 32'd0);
    chk({tag, "_instr"}, instr_if, 32'h0000_0013);
    chk({tag, "_pc"},    pc_if, pc);
  endtask

  task automatic chk_fetch(input string tag, input logic [31:0] pc);
    chk({tag, "_req"},   {31'd0, imem_req}, 32'd1);
    chk({tag, "_addr"},  imem_addr, pc);
    chk({tag, "_valid"}, {31'd0, fetch_valid}, 32'd0);
    chk({tag, "_instr"}, instr_if, 32'h0000_0013);
  endtask

  task automatic chk_valid(input string tag, input logic [31:0] pc, input logic [31:0] ins);
    chk({tag, "_req"},   {31'd0, imem_req}, 32'd0);
    chk({tag, "_valid"}, {31'd0, fetch_valid}, 32'd1);
    chk({tag, "_instr"}, instr_if, ins);
    chk({tag, "_pc"},    pc_if, pc);
  endtask

  initial begin
    rst_n = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;

    // Reset state
    step(0, 0, 0, 0, 0, 0);
    chk_fetch("rst", 32'h1000);
    chk("rst_pc", pc_if, 32'h1000);
    chk("rst_pc4", pc_plus4_if, 32'h1004);
    rst_n = 1'b1;

    // Zero-wait fetch of 0x00500093 at 0x1000
    step(1, 0, 0, 0, 0, 0);
    chk_fetch("f1", 32'h1000);
    step(0, 1, 32'h0050_0093, 0, 0, 0);
`ifdef FETCH_BYPASS_EN
    chk_valid("f1_byp", 32'h1000, 32'h0050_0093);
    chk("f1_byp_pc4", pc_plus4_if, 32'h1004);
`else
    chk_idle("f1_wait", 32'h1000);
    step(0, 0, 32'hFFFF_FFFF, 0, 0, 0);
    chk_valid("f1_val", 32'h1000, 32'h0050_0093);
    chk("f1_pc4", pc_plus4_if, 32'h1004);
`endif
    step(0, 0, 0, 0, 0, 0);
    chk_fetch("f2", 32'h1004);

    // Stall held 4 cycles in VALID
    step(1, 0, 0, 0, 0, 0);
    step(0, 1, 32'h00A0_0113, 1, 0, 0);
    chk_idle("st_wait", 32'h1004);
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 0, 1, 0, 0);
      chk_valid("st_hold", 32'h1004, 32'h00A0_0113);
    end
    step(0, 0, 0, 0, 0, 0);
    chk_valid("st_release", 32'h1004, 32'h00A0_0113);
    step(0, 0, 0, 0, 0, 0);
    chk_fetch("st_next", 32'h1008);
    chk("st_next_pc", pc_if, 32'h1008);

    // Redirect to 0x2002 in WAIT; stale response arrives 3 cycles later
    step(1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 32'h0000_2002);
    chk_idle("rd_wait", 32'h1008);
    step(0, 0, 0, 0, 0, 0);
    chk_idle("rd_drop1", 32'h2000);
    step(0, 0, 0, 0, 0, 0);
    chk_idle("rd_drop2", 32'h2000);
    step(0, 1, 32'hDEAD_BEEF, 0, 0, 0);
    chk_idle("rd_stale", 32'h2000);
    step(0, 0, 0, 0, 0, 0);
    chk_fetch("rd_fetch", 32'h2000);

    // Redirect and stall together in VALID
    step(1, 0, 0, 0, 0, 0);
    step(0, 1, 32'h1234_5678, 1, 0, 0);
    step(0, 0, 0, 1, 1, 32'h0000_3000);
    chk_valid("rs_val", 32'h2000, 32'h1234_5678);
    step(0, 0, 0, 0, 0, 0);
    chk_fetch("rs_after", 32'h3000);
    chk("rs_after_pc", pc_if, 32'h3000);

    // Grant withheld 5 cycles
    for (int i = 0; i < 5; i++) begin
      step(0, 0, 0, 0, 0, 0);
      chk_fetch("gw_hold", 32'h3000);
    end
    step(1, 0, 0, 0, 0, 0);
    chk_fetch("gw_gnt", 32'h3000);
    step(0, 0, 0, 0, 0, 0);
    chk_idle("gw_wait", 32'h3000);
    step(0, 1, 32'h0000_0033, 1, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    chk_valid("gw_val", 32'h3000, 32'h0000_0033);
    step(0, 0, 0, 0, 0, 0);
    chk_fetch("gw_next", 32'h3004);

    // Redirect to 0xFFFFFFFF (low bits dropped) from FETCH without grant
    step(0, 0, 0, 0, 1, 32'hFFFF_FFFF);
    step(0, 0, 0, 0, 0, 0);
    chk_fetch("wr_fetch", 32'hFFFF_FFFC);
    chk("wr_pc4", pc_plus4_if, 32'h0000_0000);
    step(1, 0, 0, 0, 0, 0);
    step(0, 1, 32'h0000_0093, 1, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    chk_valid("wr_val", 32'hFFFF_FFFC, 32'h0000_0093);
    step(0, 0, 0, 0, 0, 0);
    chk_fetch("wr_next", 32'h0000_0000);
    chk("wr_next_pc4", pc_plus4_if, 32'h0000_0004);

    // Redirect in FETCH with grant goes through DROP
    step(1, 0, 0, 0, 1, 32'h0000_0040);
    step(0, 0, 0, 0, 0, 0);
    chk_idle("fd_drop", 32'h0040);
    step(0, 1, 32'hBAD0_BAD0, 0, 0, 0);
    chk_idle("fd_stale", 32'h0040);
    step(0, 0, 0, 0, 0, 0);
    chk_fetch("fd_fetch", 32'h0040);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
